// File: rtl/memory_wrapper.sv
// ---------------------------------------------------------------------------
// memory_wrapper
//   RAM-backed stream FIFO. An AXI4-Stream slave stores {tlast, tstrb, tdata}
//   in a MEM_SIZE-word RAM, and an AXI4-Stream master replays the words in
//   write order. The RAM read register is the output register, which adds
//   one word of capacity beyond MEM_SIZE.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module memory_wrapper #(
   parameter int MEM_SIZE   = 4096,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
   input  logic                    s01_axis_tvalid,
   input  logic                    s01_axis_tlast,
   output logic                    s01_axis_tready,
   input  logic                    m01_axis_tready,
   output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int WORD_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;

   // Storage: one word per entry, tlast and strobes packed above the data.
   logic [WORD_WIDTH-1:0] mem_q [MEM_SIZE];

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic                  s_tready_q;
   logic                  m_tvalid_q;
   logic [WORD_WIDTH-1:0] m_word_q;

   logic                  empty;
   logic                  full_next;
   logic                  wr_en;
   logic                  rd_load;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign wr_en   = s01_axis_tvalid && s_tready_q;
   // The output register refills whenever it is free or being emptied this cycle.
   assign rd_load = !empty && (!m_tvalid_q || m01_axis_tready);

   // Next pointer values and the full flag they imply, so tready never lags.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
      rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_load};
      full_next = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge axis_aclk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
      end
   end

   // Pointers, write-side ready and the registered RAM read / output stage.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         s_tready_q <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_word_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         s_tready_q <= !full_next;
         if (rd_load) begin
            m_word_q   <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            m_tvalid_q <= 1'b1;
         end else if (m_tvalid_q && m01_axis_tready) begin
            m_tvalid_q <= 1'b0;
         end
      end
   end

   assign s01_axis_tready = s_tready_q;
   assign m01_axis_tvalid = m_tvalid_q;
   assign m01_axis_tdata  = m_word_q[DATA_WIDTH-1:0];
   assign m01_axis_tstrb  = m_word_q[DATA_WIDTH +: STRB_WIDTH];
   assign m01_axis_tlast  = m_word_q[WORD_WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_memory_wrapper.sv
// ---------------------------------------------------------------------------
// tb_memory_wrapper
//   Self-checking bench for memory_wrapper with a scoreboard queue: words are
//   pushed when the input handshake happens and popped on output handshakes.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_wrapper;

   localparam int MEM_SIZE   = 4096;
   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int WORD_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;

   logic                  clk;
   logic                  axis_areset;
   logic [DATA_WIDTH-1:0] s_tdata;
   logic [STRB_WIDTH-1:0] s_tstrb;
   logic                  s_tvalid;
   logic                  s_tlast;
   logic                  s_tready;
   logic                  m_tready;
   logic [DATA_WIDTH-1:0] m_tdata;
   logic [STRB_WIDTH-1:0] m_tstrb;
   logic                  m_tvalid;
   logic                  m_tlast;

   int errors = 0;
   int checks = 0;
   int n_out  = 0;

   logic [WORD_WIDTH-1:0] sb_q[$];

   memory_wrapper #(
      .MEM_SIZE  (MEM_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .axis_aclk      (clk),
      .axis_areset    (axis_areset),
      .s01_axis_tdata (s_tdata),
      .s01_axis_tstrb (s_tstrb),
      .s01_axis_tvalid(s_tvalid),
      .s01_axis_tlast (s_tlast),
      .s01_axis_tready(s_tready),
      .m01_axis_tready(m_tready),
      .m01_axis_tdata (m_tdata),
      .m01_axis_tstrb (m_tstrb),
      .m01_axis_tvalid(m_tvalid),
      .m01_axis_tlast (m_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: handshakes complete at the next rising edge; inputs are
   // stable from 1 time unit after the previous edge, so the falling edge
   // sees exactly what the edge will see.
   always @(negedge clk) begin
      if (!axis_areset) begin
         if (m_tvalid && m_tready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               check("unexpected_output", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("out_word", 64'({m_tlast, m_tstrb, m_tdata}), 64'(sb_q.pop_front()));
            end
         end
         if (s_tvalid && s_tready) begin
            sb_q.push_back({s_tlast, s_tstrb, s_tdata});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one word and hold it until accepted (bounded wait).
   task automatic send(input logic [DATA_WIDTH-1:0] d, input logic [STRB_WIDTH-1:0] st,
                       input logic l);
      int n;
      s_tdata  = d;
      s_tstrb  = st;
      s_tlast  = l;
      s_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_tready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) check("send_timeout", 64'(n), 64'd0);
      tick();
      s_tvalid = 1'b0;
   endtask

   task automatic wait_drained(input int budget);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || m_tvalid) && n < budget) begin
         tick();
         n++;
      end
      check("drain_done", 64'(sb_q.size() != 0 || m_tvalid), 64'd0);
   endtask

   initial begin
      int n0;
      int acc;
      int n;
      int stale;
      logic [WORD_WIDTH-1:0] first_w;

      axis_areset = 1'b1;
      s_tdata  = '0;
      s_tstrb  = '0;
      s_tlast  = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;

      // 1. Reset
      tick();
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_mout", 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}), 64'd0);
      axis_areset = 1'b0;
      @(negedge clk);
      check("rel_tready_lo", 64'(s_tready), 64'd0);
      tick();
      check("rel_tready_hi", 64'(s_tready), 64'd1);

      // 2. Four held writes of 0x68, downstream stalled
      s_tdata = 32'h68; s_tstrb = 4'h1; s_tlast = 1'b1; s_tvalid = 1'b1;
      repeat (4) tick();
      s_tvalid = 1'b0;
      check("t2_stored", 64'(sb_q.size()), 64'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_hold", 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}), {27'd0, 1'b1, 1'b1, 4'h1, 32'h68});
      end
      tick();

      // 3. Release downstream: four deliveries then idle
      n0 = n_out;
      m_tready = 1'b1;
      repeat (6) tick();
      check("t3_count", 64'(n_out - n0), 64'd4);
      check("t3_tvalid_off", 64'(m_tvalid), 64'd0);

      // 4. 0x55 stream with downstream ready; latency and transfer count
      n0 = n_out;
      s_tdata = 32'h55; s_tstrb = 4'h1; s_tlast = 1'b1; s_tvalid = 1'b1;
      tick();
      check("t4_lat_n", 64'(m_tvalid), 64'd0);
      tick();
      check("t4_lat_n1", 64'(m_tvalid), 64'd1);
      repeat (2) tick();
      s_tvalid = 1'b0;
      repeat (5) tick();
      check("t4_count", 64'(n_out - n0), 64'd4);
      check("t4_idle", 64'(m_tvalid), 64'd0);

      // 5. Overfill with distinct words, then drain
      m_tready = 1'b0;
      acc = 0;
      for (int i = 0; i < MEM_SIZE + 1; i++) begin
         send(32'hA000_0000 + 32'(i), 4'(i), i[0]);
         acc++;
      end
      check("t5_accepts", 64'(acc), 64'(MEM_SIZE + 1));
      s_tdata = 32'hBEEF_0001; s_tstrb = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t5_full_tready", 64'(s_tready), 64'd0);
      end
      check("t5_stored", 64'(sb_q.size()), 64'(MEM_SIZE + 1));
      first_w = {1'b0, 4'h0, 32'hA000_0000};
      check("t5_head", 64'({m_tlast, m_tstrb, m_tdata}), 64'(first_w));
      tick();
      m_tready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_tready && n < 20) begin
         n++;
         @(negedge clk);
      end
      tick();
      s_tvalid = 1'b0;
      wait_drained(3 * MEM_SIZE);

      // 6. Reset in mid-stream
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'hC0 + 32'(i), 4'h3, 1'b0);
      tick();
      check("t6_pre_valid", 64'(m_tvalid), 64'd1);
      #2 axis_areset = 1'b1;
      #1;
      check("t6_async_valid", 64'(m_tvalid), 64'd0);
      check("t6_async_tready", 64'(s_tready), 64'd0);
      sb_q.delete();
      tick();
      axis_areset = 1'b0;
      m_tready = 1'b1;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (m_tvalid) stale++;
      end
      check("t6_no_stale", 64'(stale), 64'd0);
      tick();
      send(32'h1234_5678, 4'hA, 1'b1);
      wait_drained(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
